// File: rtl/dac_frame_ctrl.sv
// -----------------------------------------------------------------------------
// dac_frame_ctrl
//
// Converts signed 23-bit filter samples into 12-bit offset-binary DAC codes and
// serialises them as 16-bit frames {CTRL_BITS, code}, MSB first, over a
// SYNC/SCLK/DIN interface. The DAC samples DIN on the falling edge of SCLK.
// A one-entry hold buffer lets the next sample queue up while a frame is
// shifting. A sample offered when that buffer is already full is dropped, and
// the sticky overrun flag is set.
//
// Parameters
//   CLK_DIV    clk cycles per SCLK half-period (1..255)
//   GAP_CYC    clk cycles SYNC stays high between frames (1..255)
//   CTRL_BITS  4 DAC control bits placed in front of every code
//
// Ports
//   clk           single clock, rising edge
//   reset_n       synchronous active-low reset
//   sample_in     signed two's-complement sample (23 bits)
//   sample_valid  sample_in is offered this cycle
//   clear_ovr     clear the overrun flag
//   ready         hold buffer empty; the block accepts sample_valid
//   dac_sync_n    frame enable to the DAC, active low
//   dac_sclk      serial clock to the DAC, idles high
//   dac_din       serial data to the DAC, MSB first
//   busy          the state machine is not idle
//   frame_done    one-cycle pulse in the first gap cycle after a frame
//   overrun       sticky flag: a sample was dropped
//
// Frame timing: SHIFT lasts 32*CLK_DIV cycles (16 SCLK periods) and GAP lasts
// GAP_CYC cycles. Back-to-back frames therefore repeat every
// 32*CLK_DIV + GAP_CYC cycles.
// -----------------------------------------------------------------------------
module dac_frame_ctrl #(
    parameter int unsigned CLK_DIV   = 2,
    parameter int unsigned GAP_CYC   = 4,
    parameter logic [3:0]  CTRL_BITS = 4'b0000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [22:0] sample_in,
    input  logic        sample_valid,
    input  logic        clear_ovr,
    output logic        ready,
    output logic        dac_sync_n,
    output logic        dac_sclk,
    output logic        dac_din,
    output logic        busy,
    output logic        frame_done,
    output logic        overrun
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } state_t;

    localparam logic [7:0] DIV_LAST  = 8'(CLK_DIV - 1);
    localparam logic [7:0] GAP_LAST  = 8'(GAP_CYC - 1);
    localparam logic [4:0] HALF_LAST = 5'd31;   // 16 bits x 2 SCLK half-periods

    // Adding 8192 (0x2000) leaves bits [1:0] unchanged, so bits [13:2] of the
    // 23-bit sum equal sample_in[13:2] + 0x800 modulo 2^12. Out-of-range inputs
    // wrap; they are not saturated.
    logic [11:0] code;
    logic [15:0] frame_in;
    logic        unused_sample_bits;

    assign code               = sample_in[13:2] + 12'h800;
    assign frame_in           = {CTRL_BITS, code};
    assign unused_sample_bits = ^{sample_in[22:14], sample_in[1:0]};

    state_t      state_q,      state_d;
    logic [15:0] sr_q,         sr_d;
    logic [7:0]  div_q,        div_d;
    logic [4:0]  half_q,       half_d;
    logic [7:0]  gap_q,        gap_d;
    logic [15:0] hold_q,       hold_d;
    logic        ready_q,      ready_d;
    logic        ovr_q,        ovr_d;
    logic        sync_n_q,     sync_n_d;
    logic        sclk_q,       sclk_d;
    logic        din_q,        din_d;
    logic        frame_done_q, frame_done_d;

    logic        load_en;
    logic [15:0] load_frame;

    always_comb begin
        // NOTE: every variable gets a default before any branch, so no path
        // leaves one unassigned and no latch is inferred.
        state_d      = state_q;
        sr_d         = sr_q;
        div_d        = div_q;
        half_d       = half_q;
        gap_d        = gap_q;
        hold_d       = hold_q;
        ready_d      = ready_q;
        ovr_d        = ovr_q;
        sync_n_d     = sync_n_q;
        sclk_d       = sclk_q;
        din_d        = din_q;
        frame_done_d = 1'b0;
        load_en      = 1'b0;
        load_frame   = frame_in;

        // Hold buffer and overrun. The set comes after the clear, so a drop
        // in the same cycle as clear_ovr wins.
        if (clear_ovr) begin
            ovr_d = 1'b0;
        end
        if (sample_valid && !ready_q) begin
            ovr_d = 1'b1;
        end else if (sample_valid && state_q != IDLE) begin
            hold_d  = frame_in;
            ready_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (sample_valid) begin
                    load_en = 1'b1;
                end
            end

            SHIFT: begin
                if (div_q == DIV_LAST) begin
                    div_d  = 8'd0;
                    half_d = half_q + 5'd1;
                    if (half_q == HALF_LAST) begin
                        // End of the low half after the 16th falling edge.
                        state_d      = GAP;
                        gap_d        = 8'd0;
                        sync_n_d     = 1'b1;
                        sclk_d       = 1'b1;
                        din_d        = 1'b0;
                        frame_done_d = 1'b1;
                    end else if (sclk_q) begin
                        sclk_d = 1'b0;
                    end else begin
                        // The next bit is presented together with the rising
                        // edge, so it is stable for the DAC's falling-edge sample.
                        sclk_d = 1'b1;
                        sr_d   = {sr_q[14:0], 1'b0};
                        din_d  = sr_q[14];
                    end
                end else begin
                    div_d = div_q + 8'd1;
                end
            end

            GAP: begin
                if (gap_q == GAP_LAST) begin
                    if (!ready_q) begin
                        load_en    = 1'b1;
                        load_frame = hold_q;
                        ready_d    = 1'b1;
                    end else if (sample_valid) begin
                        // The sample accepted on the last gap cycle goes straight
                        // into the shifter. If it were parked in the buffer here,
                        // the FSM would reach IDLE with the buffer full.
                        load_en = 1'b1;
                        ready_d = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    gap_d = gap_q + 8'd1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        if (load_en) begin
            state_d  = SHIFT;
            sr_d     = load_frame;
            div_d    = 8'd0;
            half_d   = 5'd0;
            sync_n_d = 1'b0;
            sclk_d   = 1'b1;
            din_d    = load_frame[15];
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignment, so every flop
        // samples the pre-edge value of every other flop.
        if (!reset_n) begin
            state_q      <= IDLE;
            sr_q         <= '0;
            div_q        <= '0;
            half_q       <= '0;
            gap_q        <= '0;
            // NOTE: the data words (sr_q, hold_q) are cleared even though
            // ready_q already marks them invalid. This keeps X out of dac_din
            // and costs only a few reset pins.
            hold_q       <= '0;
            ready_q      <= 1'b1;
            ovr_q        <= 1'b0;
            sync_n_q     <= 1'b1;
            sclk_q       <= 1'b1;
            din_q        <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            sr_q         <= sr_d;
            div_q        <= div_d;
            half_q       <= half_d;
            gap_q        <= gap_d;
            hold_q       <= hold_d;
            ready_q      <= ready_d;
            ovr_q        <= ovr_d;
            sync_n_q     <= sync_n_d;
            sclk_q       <= sclk_d;
            din_q        <= din_d;
            frame_done_q <= frame_done_d;
        end
    end

    // All DAC-facing outputs come straight from flops, so they cannot glitch.
    assign ready      = ready_q;
    assign dac_sync_n = sync_n_q;
    assign dac_sclk   = sclk_q;
    assign dac_din    = din_q;
    assign frame_done = frame_done_q;
    assign overrun    = ovr_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_dac_frame_ctrl.sv
// -----------------------------------------------------------------------------
// tb_dac_frame_ctrl
//
// Directed bench for dac_frame_ctrl. u_dut uses the default parameters
// (CLK_DIV=2, GAP_CYC=4, CTRL_BITS=0). u_fast uses CLK_DIV=1, GAP_CYC=1 and
// CTRL_BITS=4'b1010. Inputs are driven and outputs sampled 1 ns after each
// rising clk edge. Each expected value is worked out by hand from the
// conversion rule code = bits[13:2] of (sample + 8192).
// -----------------------------------------------------------------------------
module tb_dac_frame_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;

    logic [22:0] sample_in;
    logic        sample_valid;
    logic        clear_ovr;
    logic        ready, dac_sync_n, dac_sclk, dac_din, busy, frame_done, overrun;

    logic [22:0] sample_in2;
    logic        sample_valid2;
    logic        clear_ovr2;
    logic        ready2, dac_sync_n2, dac_sclk2, dac_din2, busy2, frame_done2, overrun2;

    int          vectors     = 0;
    int          miscompares = 0;

    // Bits captured on each DAC sampling (falling) edge, plus an edge count.
    logic [15:0] cap    = '0;
    logic [15:0] cap2   = '0;
    int          falls  = 0;
    int          falls2 = 0;

    localparam logic [22:0] S_M8192 = 23'h7FE000;  // -8192
    localparam logic [22:0] S_M5000 = 23'h7FEC78;  // -5000 -> 0x31E
    localparam logic [22:0] S_0     = 23'd0;       //     0 -> 0x800
    localparam logic [22:0] S_1000  = 23'd1000;    //  1000 -> 0x8FA
    localparam logic [22:0] S_8191  = 23'd8191;    //  8191 -> 0xFFF
    localparam logic [22:0] S_8192  = 23'd8192;    //  8192 -> wraps to 0x000

    always #5 clk = ~clk;

    dac_frame_ctrl u_dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .sample_in    (sample_in),
        .sample_valid (sample_valid),
        .clear_ovr    (clear_ovr),
        .ready        (ready),
        .dac_sync_n   (dac_sync_n),
        .dac_sclk     (dac_sclk),
        .dac_din      (dac_din),
        .busy         (busy),
        .frame_done   (frame_done),
        .overrun      (overrun)
    );

    dac_frame_ctrl #(
        .CLK_DIV   (1),
        .GAP_CYC   (1),
        .CTRL_BITS (4'b1010)
    ) u_fast (
        .clk          (clk),
        .reset_n      (reset_n),
        .sample_in    (sample_in2),
        .sample_valid (sample_valid2),
        .clear_ovr    (clear_ovr2),
        .ready        (ready2),
        .dac_sync_n   (dac_sync_n2),
        .dac_sclk     (dac_sclk2),
        .dac_din      (dac_din2),
        .busy         (busy2),
        .frame_done   (frame_done2),
        .overrun      (overrun2)
    );

    always @(negedge dac_sclk) begin
        cap   = {cap[14:0], dac_din};
        falls = falls + 1;
    end

    always @(negedge dac_sclk2) begin
        cap2   = {cap2[14:0], dac_din2};
        falls2 = falls2 + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_fd(output int n);
        n = 0;
        while (frame_done !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
    endtask

    task automatic wait_fd2(output int n);
        n = 0;
        while (frame_done2 !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy !== 1'b0 && n < 200) begin
            tick();
            n++;
        end
    endtask

    // Send one sample from IDLE. Check the captured frame and the time from
    // SHIFT entry to frame_done, then wait for the return to IDLE.
    task automatic send_frame(input string tag, input logic [22:0] s, input logic [15:0] exp);
        int n;
        sample_in    = s;
        sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0;
        wait_fd(n);
        chk({tag, "_lat"}, n, 64);
        chk({tag, "_frame"}, cap, exp);
        wait_idle(n);
        chk({tag, "_gap"}, n, 4);
    endtask

    initial begin
        int n;
        int f0;
        logic got_fd;
        logic early_ready;
        logic seen_high;
        logic [15:0] c1;

        reset_n       = 1'b0;
        sample_in     = '0;
        sample_valid  = 1'b0;
        clear_ovr     = 1'b0;
        sample_in2    = '0;
        sample_valid2 = 1'b0;
        clear_ovr2    = 1'b0;
        tick();
        tick();

        // ---- reset state ----
        chk("rst_ready",  ready,      1'b1);
        chk("rst_sync_n", dac_sync_n, 1'b1);
        chk("rst_sclk",   dac_sclk,   1'b1);
        chk("rst_din",    dac_din,    1'b0);
        chk("rst_fd",     frame_done, 1'b0);
        chk("rst_ovr",    overrun,    1'b0);
        chk("rst_busy",   busy,       1'b0);
        chk("rst_busy2",  busy2,      1'b0);
        reset_n = 1'b1;
        tick();

        // ---- sample 0: frame 0x0800, timing of one complete frame ----
        sample_in    = S_0;
        sample_valid = 1'b1;
        tick();                                   // first SHIFT cycle (t0)
        sample_valid = 1'b0;
        f0 = falls;
        chk("t1_busy",   busy,       1'b1);
        chk("t1_sync_n", dac_sync_n, 1'b0);
        chk("t1_sclk0",  dac_sclk,   1'b1);
        chk("t1_din0",   dac_din,    1'b0);
        chk("t1_ready",  ready,      1'b1);
        tick();
        tick();                                   // t0+2: first falling edge
        chk("t1_sclk2",  dac_sclk,   1'b0);
        wait_fd(n);
        chk("t1_fd_lat", n, 62);                  // frame_done at t0+64
        chk("t1_frame",  cap, 16'h0800);
        chk("t1_falls",  falls - f0, 16);
        chk("t1_gap_sync", dac_sync_n, 1'b1);
        chk("t1_gap_sclk", dac_sclk,   1'b1);
        chk("t1_gap_din",  dac_din,    1'b0);
        tick();
        chk("t1_fd_pulse", frame_done, 1'b0);
        tick();
        tick();                                   // t0+67, last GAP cycle
        chk("t1_busy_gap", busy, 1'b1);
        tick();
        chk("t1_idle", busy, 1'b0);

        // ---- conversion boundaries and wrap ----
        send_frame("c_m8192", S_M8192, 16'h0000);
        send_frame("c_8191",  S_8191,  16'h0FFF);
        send_frame("c_8192",  S_8192,  16'h0000);
        send_frame("c_1000",  S_1000,  16'h08FA);
        send_frame("c_m5000", S_M5000, 16'h031E);

        // ---- two valids 10 cycles apart: back-to-back frames, period 68 ----
        sample_in    = S_M5000;
        sample_valid = 1'b1;
        tick();                                   // t0
        sample_valid = 1'b0;
        repeat (9) tick();                        // t0+9
        sample_in    = S_1000;
        sample_valid = 1'b1;
        tick();                                   // t0+10, held
        sample_valid = 1'b0;
        chk("t3_ready_held", ready, 1'b0);
        n = 10;
        got_fd = 1'b0;
        early_ready = 1'b0;
        c1 = '0;
        while (!(got_fd && dac_sync_n === 1'b0) && n < 200) begin
            tick();
            n++;
            if (frame_done === 1'b1) begin
                got_fd = 1'b1;
                c1 = cap;
            end
            if (ready !== 1'b0 && !(got_fd && dac_sync_n === 1'b0)) early_ready = 1'b1;
        end
        chk("t3_period",     n, 68);
        chk("t3_ready_low",  early_ready, 1'b0);
        chk("t3_frame1",     c1, 16'h031E);
        chk("t3_ready_drain", ready, 1'b1);
        wait_fd(n);
        chk("t3_lat2",   n, 64);
        chk("t3_frame2", cap, 16'h08FA);
        wait_idle(n);
        chk("t3_idle", n, 4);

        // ---- overrun: third valid dropped, clear_ovr, set wins, drain drop ----
        sample_in    = S_1000;
        sample_valid = 1'b1;
        tick();                                   // t0: A into shifter
        sample_in = S_8191;
        tick();                                   // t0+1: B into hold
        chk("t4_ready_b", ready,   1'b0);
        chk("t4_ovr_b",   overrun, 1'b0);
        sample_in = S_0;
        tick();                                   // t0+2: C dropped
        chk("t4_ovr_c",   overrun, 1'b1);
        chk("t4_ready_c", ready,   1'b0);
        sample_valid = 1'b0;
        clear_ovr    = 1'b1;
        tick();                                   // t0+3
        chk("t4_clear", overrun, 1'b0);
        sample_in    = S_M8192;
        sample_valid = 1'b1;
        tick();                                   // t0+4: clear together with drop
        chk("t4_set_wins", overrun, 1'b1);
        sample_valid = 1'b0;
        tick();                                   // t0+5
        chk("t4_clear2", overrun, 1'b0);
        clear_ovr = 1'b0;
        wait_fd(n);
        chk("t4_lat",    n, 59);
        chk("t4_frameA", cap, 16'h08FA);
        repeat (3) tick();                        // t0+67, last GAP cycle
        chk("t4_ready_pre", ready,      1'b0);
        chk("t4_sync_pre",  dac_sync_n, 1'b1);
        sample_in    = S_M5000;
        sample_valid = 1'b1;
        tick();                                   // t0+68: drain, E dropped
        sample_valid = 1'b0;
        chk("t4_drain_ovr",   overrun,    1'b1);
        chk("t4_drain_ready", ready,      1'b1);
        chk("t4_drain_sync",  dac_sync_n, 1'b0);
        wait_fd(n);
        chk("t4_frameB", cap, 16'h0FFF);
        wait_idle(n);
        chk("t4_idle", n, 4);
        repeat (20) tick();
        chk("t4_no_extra", dac_sync_n, 1'b1);
        clear_ovr = 1'b1;
        tick();
        clear_ovr = 1'b0;
        chk("t4_final_clear", overrun, 1'b0);

        // ---- reset during bit 7 with the hold buffer full ----
        sample_in    = S_0;
        sample_valid = 1'b1;
        tick();                                   // t0
        sample_in = S_8191;
        tick();                                   // t0+1: held
        sample_valid = 1'b0;
        repeat (28) tick();                       // t0+29, inside bit 7
        chk("t5_pre_ready", ready, 1'b0);
        chk("t5_pre_busy",  busy,  1'b1);
        reset_n      = 1'b0;
        sample_valid = 1'b1;                      // must be ignored in reset
        tick();
        f0 = falls;
        chk("t5_sync",  dac_sync_n, 1'b1);
        chk("t5_sclk",  dac_sclk,   1'b1);
        chk("t5_din",   dac_din,    1'b0);
        chk("t5_ready", ready,      1'b1);
        chk("t5_busy",  busy,       1'b0);
        tick();
        chk("t5_busy_hold", busy, 1'b0);
        reset_n      = 1'b1;
        sample_valid = 1'b0;
        repeat (100) tick();
        chk("t5_no_edges", falls - f0, 0);
        chk("t5_no_frame", dac_sync_n, 1'b1);
        chk("t5_idle",     busy,       1'b0);

        // ---- CLK_DIV=1, GAP_CYC=1: SCLK toggles every cycle, period 33 ----
        sample_in2    = S_0;
        sample_valid2 = 1'b1;
        tick();                                   // t0
        sample_valid2 = 1'b0;
        f0 = falls2;
        chk("t6_sclk0", dac_sclk2,   1'b1);
        chk("t6_sync0", dac_sync_n2, 1'b0);
        chk("t6_din0",  dac_din2,    1'b1);       // CTRL_BITS MSB
        tick();                                   // t0+1
        chk("t6_sclk1", dac_sclk2, 1'b0);
        sample_in2    = S_8191;
        sample_valid2 = 1'b1;
        tick();                                   // t0+2: held
        sample_valid2 = 1'b0;
        chk("t6_sclk2",  dac_sclk2, 1'b1);
        chk("t6_ready2", ready2,    1'b0);
        n = 2;
        seen_high = 1'b0;
        c1 = '0;
        while (!(seen_high && dac_sync_n2 === 1'b0) && n < 100) begin
            tick();
            n++;
            if (dac_sync_n2 === 1'b1) seen_high = 1'b1;
            if (frame_done2 === 1'b1) c1 = cap2;
        end
        chk("t6_period", n, 33);
        chk("t6_frame1", c1, 16'hA800);
        wait_fd2(n);
        chk("t6_lat2",   n, 32);
        chk("t6_frame2", cap2, 16'hAFFF);
        chk("t6_falls",  falls2 - f0, 32);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/dac_frame_ctrl.md
DAC_FRAME_CTRL -- requirements
Module: dac_frame_ctrl

Interface
REQ-001 SHALL have parameter CLK_DIV, default 2, meaning clk cycles per SCLK half-period; legal range 1..255.
REQ-002 SHALL have parameter GAP_CYC, default 4, meaning clk cycles SYNC stays high between frames; legal range 1..255.
REQ-003 SHALL have parameter CTRL_BITS, default 4'b0000, meaning the 4 DAC control bits prefixed to each frame.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-005 SHALL have port reset_n, input, 1 bit: synchronous, active-low reset.
REQ-006 SHALL have port sample_in, input, 23 bits: signed two's-complement filter output.
REQ-007 SHALL have port sample_valid, input, 1 bit: sample_in is offered this cycle.
REQ-008 SHALL have port clear_ovr, input, 1 bit: clears the overrun flag.
REQ-009 SHALL have port ready, output, 1 bit: the hold buffer is empty and the block accepts sample_valid.
REQ-010 SHALL have port dac_sync_n, output, 1 bit: frame-enable output to the DAC, active low.
REQ-011 SHALL have port dac_sclk, output, 1 bit: serial clock output to the DAC.
REQ-012 SHALL have port dac_din, output, 1 bit: serial data output to the DAC, MSB first.
REQ-013 SHALL have port busy, output, 1 bit: the state is not IDLE.
REQ-014 SHALL have port frame_done, output, 1 bit: one-cycle pulse at the end of each frame.
REQ-015 SHALL have port overrun, output, 1 bit: sticky flag set when a sample was dropped.

Function
REQ-016 Conversion SHALL be: code[11:0] = bits [13:2] of (sample_in + 23'd8192), using 23-bit modulo addition; inputs outside -8192..8191 wrap and are not saturated.
REQ-017 Frame SHALL be 16 bits, {CTRL_BITS, code}, shifted MSB first.
REQ-018 The state machine SHALL have three states: IDLE, SHIFT and GAP.
REQ-019 In IDLE, sample_valid=1 SHALL load the converted frame into the shift register at that edge, with state SHIFT on the next cycle.
REQ-020 In SHIFT, dac_sync_n SHALL be 0; dac_sclk SHALL start at 1 and toggle every CLK_DIV cycles; dac_din SHALL change only in the same cycle dac_sclk rises, or on SHIFT entry; the DAC samples on the falling edge.
REQ-021 After the 16th falling edge of dac_sclk, state SHALL go to GAP: dac_sync_n=1, dac_sclk=1, dac_din=0.
REQ-022 frame_done SHALL be high for exactly the first GAP cycle.
REQ-023 GAP SHALL last GAP_CYC cycles, then go to SHIFT if the hold buffer is full (the buffer drains into the shift register), otherwise to IDLE.
REQ-024 Frame period SHALL be exactly 32*CLK_DIV + GAP_CYC cycles.
REQ-025 The hold buffer SHALL be 1 entry holding the converted frame; ready = not hold_full, driven from a register.
REQ-026 In SHIFT or GAP, sample_valid with ready=1 SHALL store the sample into the hold buffer.
REQ-027 sample_valid with ready=0 SHALL drop the sample and set overrun; the buffer contents are unchanged.
REQ-028 When the hold buffer drains and sample_valid arrives in the same cycle, the new sample SHALL be dropped and overrun set, because ready was 0.
REQ-029 clear_ovr=1 SHALL clear overrun next cycle; if a drop happens in the same cycle, set SHALL win.
REQ-030 busy SHALL equal (state != IDLE).

Reset
REQ-031 reset_n=0 at a clk edge SHALL force: state IDLE, hold buffer empty, ready=1, dac_sync_n=1, dac_sclk=1, dac_din=0, frame_done=0, overrun=0.
REQ-032 Reset asserted mid-frame SHALL abort the frame immediately, with no further dac_sclk edges, and SHALL discard held data.
REQ-033 sample_valid while reset_n=0 SHALL be ignored.

Verification
REQ-034 sample_in=0, CLK_DIV=2, GAP_CYC=4 -> din bit sequence 0000_1000_0000_0000 (0x0800); 16 falling edges; frame_done pulses 64 cycles after SHIFT entry; busy low 4 cycles later.
REQ-035 sample_in=-8192 -> code 0x000; sample_in=8191 -> code 0xFFF; sample_in=8192 -> wraps to 0x000.
REQ-036 Two valids 10 cycles apart -> second frame starts right after GAP (period 68 cycles); ready is low between the second accept and the drain.
REQ-037 Three valids during one frame -> the third is dropped and overrun=1; clear_ovr pulse -> overrun=0 next cycle; clear_ovr together with a drop -> overrun stays 1.
REQ-038 reset_n=0 at bit 7 of a frame with the hold buffer full -> next cycle sync_n=1, sclk=1, ready=1, busy=0; no frame follows.
REQ-039 CLK_DIV=1, GAP_CYC=1 -> dac_sclk toggles every cycle; frame period 33 cycles.
